// File: rtl/regfile_arb.sv
// regfile_arb: two-master round-robin arbiter in front of an external
// single-port register file, with a zero-fill (INIT) sequence.
// Grants are combinational; every register-file access is registered one
// cycle after the transfer, and read data returns one cycle after that.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | arbitrate m0/m1, issue one access per transfer
// ST_INIT | write zero to addresses 0..DATA_D-1, one per cycle, no grants

module regfile_arb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_D = 32
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              init_,
    input  logic              m0_req_,
    input  logic              m0_we_,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req_,
    input  logic              m1_we_,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt_,
    output logic              m1_gnt_,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_d_in,
    output logic              rf_we_,
    input  logic [DATA_W-1:0] rf_d_out,
    output logic              busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } state_t;

    localparam int              CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DATA_D);

    state_t            state, state_nxt;
    logic              rr, rr_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] din_nxt;
    logic              we_nxt;
    logic              rd0_pend, rd1_pend;
    logic              rd0_nxt, rd1_nxt;
    logic              xfer0, xfer1;

    assign busy  = (state == ST_INIT);
    assign xfer0 = ~m0_req_ & ~m0_gnt_;
    assign xfer1 = ~m1_req_ & ~m1_gnt_;

    // Grant: only in IDLE, out of reset, and not while init_ is being taken.
    // m0 wins if it is alone or rr points at it; otherwise m1 if requesting.
    always_comb begin
        m0_gnt_ = 1'b1;
        m1_gnt_ = 1'b1;
        if (reset_ && (state == ST_IDLE) && init_) begin
            if (!m0_req_ && (m1_req_ || !rr)) begin
                m0_gnt_ = 1'b0;
            end else if (!m1_req_) begin
                m1_gnt_ = 1'b0;
            end
        end
    end

    // Next-state, round-robin pointer, fill counter and register-file access.
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        cnt_nxt   = cnt;
        addr_nxt  = rf_addr;
        din_nxt   = rf_d_in;
        we_nxt    = 1'b1;
        rd0_nxt   = 1'b0;
        rd1_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!init_) begin
                    state_nxt = ST_INIT;
                    cnt_nxt   = '0;
                end else if (xfer0) begin
                    addr_nxt = m0_addr;
                    din_nxt  = m0_wdata;
                    we_nxt   = m0_we_;
                    rd0_nxt  = m0_we_;
                    rr_nxt   = 1'b1;
                end else if (xfer1) begin
                    addr_nxt = m1_addr;
                    din_nxt  = m1_wdata;
                    we_nxt   = m1_we_;
                    rd1_nxt  = m1_we_;
                    rr_nxt   = 1'b0;
                end
            end
            ST_INIT: begin
                addr_nxt = cnt[ADDR_W-1:0];
                din_nxt  = '0;
                we_nxt   = 1'b0;
                cnt_nxt  = cnt + 1'b1;
                // The counter is one bit wider than the address so the last
                // write is recognised without wrapping into a second pass.
                if (cnt_nxt == CNT_END) begin
                    state_nxt = ST_IDLE;
                    rr_nxt    = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, pointer and fill counter.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= ST_IDLE;
            rr    <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            rr    <= rr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered register-file access port.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rf_addr <= '0;
            rf_d_in <= '0;
            rf_we_  <= 1'b1;
        end else begin
            rf_addr <= addr_nxt;
            rf_d_in <= din_nxt;
            rf_we_  <= we_nxt;
        end
    end

    // Read return: capture rf_d_out one cycle after the read was issued.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rd0_pend  <= 1'b0;
            rd1_pend  <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            rd0_pend  <= rd0_nxt;
            rd1_pend  <= rd1_nxt;
            m0_rvalid <= rd0_pend;
            m1_rvalid <= rd1_pend;
            if (rd0_pend) begin
                m0_rdata <= rf_d_out;
            end
            if (rd1_pend) begin
                m1_rdata <= rf_d_out;
            end
        end
    end

endmodule

// File: tb/tb_regfile_arb.sv
// Bench for regfile_arb: a behavioural register file on the rf_* port, a
// transaction-level model of the arbiter, a per-cycle compare process and
// directed scenarios with literal expectations.

module tb_regfile_arb;

    logic        clk;
    logic        reset_;
    logic        init_;
    logic        m0_req_, m0_we_, m1_req_, m1_we_;
    logic [4:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt_, m1_gnt_, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [4:0]  rf_addr;
    logic [31:0] rf_d_in, rf_d_out;
    logic        rf_we_;
    logic        busy;

    regfile_arb #(.DATA_W(32), .ADDR_W(5), .DATA_D(32)) dut (
        .clk(clk), .reset_(reset_), .init_(init_),
        .m0_req_(m0_req_), .m0_we_(m0_we_), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req_(m1_req_), .m1_we_(m1_we_), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt_(m0_gnt_), .m1_gnt_(m1_gnt_),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .rf_addr(rf_addr), .rf_d_in(rf_d_in), .rf_we_(rf_we_),
        .rf_d_out(rf_d_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External register file: synchronous write, combinational read.
    logic [31:0] ram [32] = '{default: 32'h0};
    always @(posedge clk) if (!rf_we_) ram[rf_addr] <= rf_d_in;
    assign rf_d_out = ram[rf_addr];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Which master the rules grant this cycle: -1 none, 0 or 1.
    function automatic int pick(input logic rst_n, input logic in_init, input logic ini_n,
                                input logic r0_, input logic r1_, input int rr);
        if (!rst_n || in_init || !ini_n) return -1;
        if (!r0_ && !r1_) return rr;
        if (!r0_) return 0;
        if (!r1_) return 1;
        return -1;
    endfunction

    // Transaction-level model.
    logic [31:0] mem_m [32] = '{default: 32'h0};
    logic        m_init;
    int          m_left, m_rr, who;
    logic        exp_we, exp_rv0, exp_rv1, p_rd0, p_rd1;
    logic [4:0]  exp_addr;
    logic [31:0] exp_din, exp_rd0, exp_rd1, p_val0, p_val1;

    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            m_init = 0; m_left = 0; m_rr = 0;
            exp_we = 1; exp_addr = 0; exp_din = 0;
            exp_rv0 = 0; exp_rv1 = 0; exp_rd0 = 0; exp_rd1 = 0;
            p_rd0 = 0; p_rd1 = 0;
        end else begin
            exp_rv0 = p_rd0;
            exp_rv1 = p_rd1;
            if (p_rd0) exp_rd0 = p_val0;
            if (p_rd1) exp_rd1 = p_val1;
            p_rd0 = 0;
            p_rd1 = 0;
            if (m_init) begin
                exp_we   = 0;
                exp_addr = 5'(32 - m_left);
                exp_din  = 0;
                m_left   = m_left - 1;
                if (m_left == 0) begin
                    m_init = 0;
                    m_rr   = 0;
                end
            end else if (!init_) begin
                m_init = 1;
                m_left = 32;
                exp_we = 1;
                for (int i = 0; i < 32; i++) mem_m[i] = 0;
            end else begin
                who = pick(1'b1, 1'b0, 1'b1, m0_req_, m1_req_, m_rr);
                exp_we = 1;
                if (who >= 0) begin
                    exp_addr = (who == 0) ? m0_addr : m1_addr;
                    exp_din  = (who == 0) ? m0_wdata : m1_wdata;
                    exp_we   = (who == 0) ? m0_we_ : m1_we_;
                    if (!exp_we) begin
                        mem_m[exp_addr] = exp_din;
                    end else if (who == 0) begin
                        p_rd0 = 1; p_val0 = mem_m[exp_addr];
                    end else begin
                        p_rd1 = 1; p_val1 = mem_m[exp_addr];
                    end
                    m_rr = 1 - who;
                end
            end
        end
    end

    // Per-cycle compare of every output against the model.
    int g_exp;
    int rv0_cnt = 0;
    int rv1_cnt = 0;
    always @(negedge clk) begin
        g_exp = pick(reset_, m_init, init_, m0_req_, m1_req_, m_rr);
        chk("m0_gnt_", m0_gnt_, (g_exp == 0) ? 32'd0 : 32'd1);
        chk("m1_gnt_", m1_gnt_, (g_exp == 1) ? 32'd0 : 32'd1);
        chk("busy", busy, m_init);
        chk("rf_we_", rf_we_, exp_we);
        chk("rf_addr", rf_addr, exp_addr);
        chk("rf_d_in", rf_d_in, exp_din);
        chk("m0_rvalid", m0_rvalid, exp_rv0);
        chk("m1_rvalid", m1_rvalid, exp_rv1);
        chk("m0_rdata", m0_rdata, exp_rd0);
        chk("m1_rdata", m1_rdata, exp_rd1);
        if (m0_rvalid) rv0_cnt++;
        if (m1_rvalid) rv1_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    int seq [4];
    int n, gap, run2, guard, base0, base1, nw, nb;

    initial begin
        reset_ = 0; init_ = 1;
        m0_req_ = 0; m0_we_ = 1; m0_addr = 0; m0_wdata = 0;
        m1_req_ = 1; m1_we_ = 1; m1_addr = 0; m1_wdata = 0;

        // Reset with m0 requesting.
        repeat (3) begin
            @(negedge clk);
            chk("rst_m0_gnt_", m0_gnt_, 1);
            chk("rst_rf_we_", rf_we_, 1);
            chk("rst_busy", busy, 0);
        end
        tick(); m0_req_ = 1; reset_ = 1;
        tick();

        // Write 0xDEADBEEF to 5, read it back the next cycle.
        m0_req_ = 0; m0_we_ = 0; m0_addr = 5; m0_wdata = 32'hDEADBEEF;
        tick(); m0_we_ = 1;
        tick(); m0_req_ = 1;
        @(negedge clk); chk("wr_rd_rvalid_early", m0_rvalid, 0);
        @(negedge clk); chk("wr_rd_rvalid", m0_rvalid, 1);
        chk("wr_rd_rdata", m0_rdata, 32'hDEADBEEF);
        @(negedge clk); chk("wr_rd_rvalid_one_cycle", m0_rvalid, 0);

        // m1 writes addr 7, leaving rr pointing at m0.
        tick(); m1_req_ = 0; m1_we_ = 0; m1_addr = 7; m1_wdata = 32'h1111_2222;
        tick(); m1_req_ = 1;
        tick();

        // Both masters read for 4 cycles.
        base0 = rv0_cnt; base1 = rv1_cnt;
        m0_req_ = 0; m0_we_ = 1; m0_addr = 5;
        m1_req_ = 0; m1_we_ = 1; m1_addr = 7;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seq[i] = !m0_gnt_ ? 0 : (!m1_gnt_ ? 1 : 9);
            tick();
        end
        m0_req_ = 1; m1_req_ = 1;
        repeat (3) tick();
        chk("rr_g0", seq[0], 0);
        chk("rr_g1", seq[1], 1);
        chk("rr_g2", seq[2], 0);
        chk("rr_g3", seq[3], 1);
        chk("rr_rv0_count", rv0_cnt - base0, 2);
        chk("rr_rv1_count", rv1_cnt - base1, 2);
        chk("rr_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("rr_m1_rdata", m1_rdata, 32'h1111_2222);

        // INIT pulse with m1 holding a read of addr 5.
        m1_req_ = 0; m1_we_ = 1; m1_addr = 5; init_ = 0;
        @(negedge clk); chk("init_blocks_gnt", m1_gnt_, 1);
        tick(); init_ = 1;
        n = 0; guard = 0;
        @(negedge clk);
        while (busy && guard < 100) begin n++; guard++; @(negedge clk); end
        chk("init_busy_cycles", n, 32);
        chk("post_init_m1_gnt_", m1_gnt_, 0);
        tick(); m1_req_ = 1;
        @(negedge clk);
        @(negedge clk);
        chk("post_init_rvalid", m1_rvalid, 1);
        chk("post_init_rdata", m1_rdata, 0);

        // Reset in the middle of INIT at address 10.
        tick(); init_ = 0;
        tick(); init_ = 1;
        guard = 0;
        @(negedge clk);
        while (!(rf_we_ == 1'b0 && rf_addr == 5'd10) && guard < 100) begin
            guard++; @(negedge clk);
        end
        chk("midinit_addr", rf_addr, 10);
        #1 reset_ = 0;
        #1 chk("abort_rf_we_", rf_we_, 1);
        chk("abort_busy", busy, 0);
        @(posedge clk); @(posedge clk); #2 reset_ = 1;
        nw = 0; nb = 0;
        repeat (40) begin
            @(negedge clk);
            if (!rf_we_) nw++;
            if (busy) nb++;
        end
        chk("after_abort_writes", nw, 0);
        chk("after_abort_busy", nb, 0);

        // init_ held low through INIT: one full pass, then a second one.
        tick(); init_ = 0;
        guard = 0;
        @(negedge clk);
        while (!busy && guard < 10) begin guard++; @(negedge clk); end
        n = 0;
        while (busy && n < 100) begin n++; @(negedge clk); end
        gap = 0;
        while (!busy && gap < 10) begin gap++; @(negedge clk); end
        run2 = 0;
        while (busy && run2 < 100) begin
            run2++;
            if (run2 == 3) init_ = 1;
            @(negedge clk);
        end
        init_ = 1;
        nb = 0;
        repeat (5) begin @(negedge clk); if (busy) nb++; end
        chk("held_pass1", n, 32);
        chk("held_gap", gap, 1);
        chk("held_pass2", run2, 32);
        chk("held_no_pass3", nb, 0);

        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_arb.md
REGFILE_ARB -- requirements
Module: regfile_arb

Parameters
REQ-001 DATA_W, 32, register data width in bits.
REQ-002 ADDR_W, 5, register address width in bits.
REQ-003 DATA_D, 32, register count; SHALL equal 2**ADDR_W.

Interface
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset_  in  1  reset, asynchronous, active-low.
REQ-006 init_  in  1  active-low request to zero-fill the register file.
REQ-007 m0_req_ / m1_req_  in  1  active-low access request, master 0 / master 1.
REQ-008 m0_we_ / m1_we_  in  1  active-low write select; high means read.
REQ-009 m0_addr / m1_addr  in  ADDR_W  target register.
REQ-010 m0_wdata / m1_wdata  in  DATA_W  write data.
REQ-011 m0_gnt_ / m1_gnt_  out  1  active-low grant, combinational.
REQ-012 m0_rvalid / m1_rvalid  out  1  active-high, one-cycle read-data strobe.
REQ-013 m0_rdata / m1_rdata  out  DATA_W  read data, held until the next read return to that master.
REQ-014 rf_addr  out  ADDR_W  register-file address, registered.
REQ-015 rf_d_in  out  DATA_W  register-file write data, registered.
REQ-016 rf_we_  out  1  register-file active-low write enable, registered.
REQ-017 rf_d_out  in  DATA_W  register-file combinational read data.
REQ-018 busy  out  1  high while in INIT.

Function
REQ-019 FSM states: IDLE (arbitrate) and INIT (zero-fill).
REQ-020 Transfer: occurs at a rising edge where mX_req_=0 and mX_gnt_=0.
REQ-021 Grant rules:
- At most one gnt_ is low per cycle.
- No gnt_ is low in INIT.
- No gnt_ is low in the cycle init_ is sampled low in IDLE.
REQ-022 Single requester in IDLE: the requesting master is granted in the same cycle.
REQ-023 Both requesting: the master selected by the round-robin pointer rr (0 = m0) is granted.
REQ-024 rr update: after each transfer, rr SHALL point to the master not granted.
REQ-025 Access issue: the transfer at edge E0 drives rf_addr, rf_d_in and rf_we_ (low for a write, else high) during E0..E1.
REQ-026 Idle cycles: with no transfer, rf_we_ SHALL be 1 and rf_addr/rf_d_in SHALL hold their previous values.
REQ-027 Read return: for a read transferred at E0:
- rf_d_out is captured into mX_rdata at E1.
- mX_rvalid is high for exactly E1..E2.
REQ-028 Write-then-read: a write transferred at E0 followed by a read of the same address transferred at E1 SHALL return the new data.
REQ-029 Throughput: one transfer per cycle, with no bubble between back-to-back transfers.
REQ-030 INIT entry: init_ sampled low in IDLE enters INIT; busy is high from the next cycle.
REQ-031 INIT sequence:
- Issues 32 consecutive writes of zero to addresses 0..31, one per cycle, with rf_we_ low.
- Then returns to IDLE with rr=0 and busy=0.
REQ-032 init_ sampled low while in INIT SHALL be ignored.
REQ-033 Requests held during INIT SHALL remain pending, not granted, and SHALL be served after return to IDLE.
REQ-034 Address counter: internal, ADDR_W+1 bits; INIT ends when it reaches DATA_D, with no wrap into a second pass.
REQ-035 Request changes: requests withdrawn before grant SHALL be dropped without side effects.

Reset
REQ-036 While reset_=0, asynchronously:
- state=IDLE, rr=0, rf_we_=1, rf_addr=0, rf_d_in=0.
- m0/m1_rvalid=0, m0/m1_rdata=0, busy=0, both gnt_=1.
REQ-037 Reset mid-INIT or mid-read SHALL abort the operation, with no rvalid afterwards; INIT does not resume.
REQ-038 First grant after reset release SHALL occur no earlier than the first rising edge with reset_=1.

Verification
REQ-039 Reset: reset_=0 with m0_req_=0 -> m0_gnt_=1, rf_we_=1, busy=0 for the whole reset.
REQ-040 Write-then-read: m0 writes 0xDEADBEEF to addr 5, then m0 reads addr 5 next cycle -> m0_rvalid one cycle later with m0_rdata=0xDEADBEEF.
REQ-041 Round-robin: both masters hold req_ low for 4 cycles, rr=0 -> grants m0,m1,m0,m1; each rvalid on the correct master only.
REQ-042 INIT: init_ pulse with m1_req_ held low -> busy high 32 cycles, addrs 0..31 written 0, then m1 granted in the first IDLE cycle; a subsequent read of addr 5 returns 0.
REQ-043 Reset mid-INIT at address 10: reset_ low -> immediate rf_we_=1; after release, state IDLE and no further zero writes.
REQ-044 init_ held low through INIT -> exactly one 32-write pass, then a new INIT only if init_ is still low in IDLE.
